// File: rtl/motor_drive_sequencer_if.sv
// Drive-command handshake between the steering/speed logic and the motor sequencer.
// The master issues per-wheel speed/direction commands and the slave accepts them when ready.
interface motor_drive_sequencer_if #(
  parameter int DUTY_W = 7
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir_l;
  logic [DUTY_W-1:0] cmd_spd_l;
  logic              cmd_dir_r;
  logic [DUTY_W-1:0] cmd_spd_r;

  modport master (
    output cmd_valid, cmd_dir_l, cmd_spd_l, cmd_dir_r, cmd_spd_r,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir_l, cmd_spd_l, cmd_dir_r, cmd_spd_r,
    output cmd_ready
  );
endinterface

// File: rtl/motor_drive_sequencer.sv
// Dual-channel motor driver sequencer: soft-start ramping, reversal short-brake, standby and command watchdog.
// Optional soft-stop ramp-down on disable is enabled by defining MOTOR_DRIVE_SEQUENCER_SOFTSTOP_EN.
module motor_drive_sequencer #(
  parameter int DIV_CNT     = 16384,
  parameter int DUTY_W      = 7,
  parameter int DUTY_MAX    = 100,
  parameter int RAMP_STEP   = 1,
  parameter int BRAKE_TICKS = 8,
  parameter int WDT_TICKS   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  motor_drive_sequencer_if.slave cmd,
  output logic [DUTY_W-1:0]      duty_l,
  output logic [DUTY_W-1:0]      duty_r,
  output logic                   ain1,
  output logic                   ain2,
  output logic                   bin1,
  output logic                   bin2,
  output logic                   stnby,
  output logic [2:0]             state,
  output logic                   fault
);
  localparam int CW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam int BW = (BRAKE_TICKS > 1) ? $clog2(BRAKE_TICKS) : 1;
  localparam int WW = (WDT_TICKS > 1) ? $clog2(WDT_TICKS) : 1;

  localparam logic [CW-1:0]     TICK_LAST  = CW'(DIV_CNT - 1);
  localparam logic [BW-1:0]     BRAKE_LAST = BW'(BRAKE_TICKS - 1);
  localparam logic [WW-1:0]     WDT_LAST   = WW'(WDT_TICKS - 1);
  localparam logic [DUTY_W-1:0] STEP       = DUTY_W'(RAMP_STEP);
  localparam logic [DUTY_W-1:0] DMAX       = DUTY_W'(DUTY_MAX);

  typedef enum logic [2:0] {
    ST_STBY  = 3'd0,
    ST_RUN   = 3'd1,
    ST_BRAKE = 3'd2,
    ST_FAULT = 3'd3
`ifdef MOTOR_DRIVE_SEQUENCER_SOFTSTOP_EN
    , ST_STOP = 3'd4
`endif
  } state_t;

  state_t            cur_st;
  logic [CW-1:0]     tick_cnt;
  logic [BW-1:0]     brake_cnt;
  logic [WW-1:0]     wdt_cnt;
  logic [DUTY_W-1:0] tgt_l, tgt_r;
  logic              dir_l, dir_r;
  logic              pend_l, pend_r;
  logic              tick;
  logic              accept;
  logic              reversal;

  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] goal);
    logic [DUTY_W-1:0] diff;
    if (cur < goal) begin
      diff = goal - cur;
      return (diff > STEP) ? cur + STEP : goal;
    end
    diff = cur - goal;
    return (diff > STEP) ? cur - STEP : goal;
  endfunction

  function automatic logic [DUTY_W-1:0] clamp(input logic [DUTY_W-1:0] spd);
    return (spd > DMAX) ? DMAX : spd;
  endfunction

  assign tick          = (tick_cnt == TICK_LAST);
  assign cmd.cmd_ready = (cur_st == ST_RUN);
  assign accept        = cmd.cmd_valid && (cur_st == ST_RUN);
  // Only a wheel that is actually spinning needs the short brake before flipping direction.
  assign reversal      = ((cmd.cmd_dir_l != dir_l) && (duty_l != '0)) ||
                         ((cmd.cmd_dir_r != dir_r) && (duty_r != '0));

  assign state = cur_st;
  assign stnby = (cur_st != ST_STBY);
  assign fault = (cur_st == ST_FAULT);

  always_comb begin
    ain1 = 1'b0;
    ain2 = 1'b0;
    bin1 = 1'b0;
    bin2 = 1'b0;
    case (cur_st)
      ST_RUN
`ifdef MOTOR_DRIVE_SEQUENCER_SOFTSTOP_EN
      , ST_STOP
`endif
      : begin
        ain1 = ~dir_l;
        ain2 = dir_l;
        bin1 = ~dir_r;
        bin2 = dir_r;
      end
      ST_BRAKE, ST_FAULT: begin
        ain1 = 1'b1;
        ain2 = 1'b1;
        bin1 = 1'b1;
        bin2 = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st    <= ST_STBY;
      tick_cnt  <= '0;
      brake_cnt <= '0;
      wdt_cnt   <= '0;
      tgt_l     <= '0;
      tgt_r     <= '0;
      duty_l    <= '0;
      duty_r    <= '0;
      dir_l     <= 1'b0;
      dir_r     <= 1'b0;
      pend_l    <= 1'b0;
      pend_r    <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      case (cur_st)
        ST_STBY: begin
          duty_l    <= '0;
          duty_r    <= '0;
          tgt_l     <= '0;
          tgt_r     <= '0;
          dir_l     <= 1'b0;
          dir_r     <= 1'b0;
          pend_l    <= 1'b0;
          pend_r    <= 1'b0;
          wdt_cnt   <= '0;
          brake_cnt <= '0;
          if (enable) cur_st <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable) begin
`ifdef MOTOR_DRIVE_SEQUENCER_SOFTSTOP_EN
            cur_st <= ST_STOP;
`else
            cur_st <= ST_STBY;
            duty_l <= '0;
            duty_r <= '0;
`endif
          end else if (accept && reversal) begin
            cur_st    <= ST_BRAKE;
            tgt_l     <= clamp(cmd.cmd_spd_l);
            tgt_r     <= clamp(cmd.cmd_spd_r);
            pend_l    <= cmd.cmd_dir_l;
            pend_r    <= cmd.cmd_dir_r;
            duty_l    <= '0;
            duty_r    <= '0;
            brake_cnt <= '0;
            wdt_cnt   <= '0;
          end else begin
            // Ramp toward the previously latched targets; a FAULT below overrides with zero duty.
            if (tick) begin
              duty_l <= step_toward(duty_l, tgt_l);
              duty_r <= step_toward(duty_r, tgt_r);
            end
            if (accept) begin
              tgt_l   <= clamp(cmd.cmd_spd_l);
              tgt_r   <= clamp(cmd.cmd_spd_r);
              dir_l   <= cmd.cmd_dir_l;
              dir_r   <= cmd.cmd_dir_r;
              wdt_cnt <= '0;
            end else if (tick) begin
              if (wdt_cnt == WDT_LAST) begin
                cur_st <= ST_FAULT;
                duty_l <= '0;
                duty_r <= '0;
              end else begin
                wdt_cnt <= wdt_cnt + 1'b1;
              end
            end
          end
        end
        ST_BRAKE: begin
          if (!enable) begin
            cur_st <= ST_STBY;
          end else if (tick) begin
            if (brake_cnt == BRAKE_LAST) begin
              cur_st    <= ST_RUN;
              dir_l     <= pend_l;
              dir_r     <= pend_r;
              brake_cnt <= '0;
            end else begin
              brake_cnt <= brake_cnt + 1'b1;
            end
          end
        end
        ST_FAULT: begin
          if (!enable) cur_st <= ST_STBY;
        end
`ifdef MOTOR_DRIVE_SEQUENCER_SOFTSTOP_EN
        ST_STOP: begin
          if (enable) begin
            cur_st <= ST_RUN;
          end else if (duty_l == '0 && duty_r == '0) begin
            cur_st <= ST_STBY;
          end else if (tick) begin
            duty_l <= step_toward(duty_l, '0);
            duty_r <= step_toward(duty_r, '0);
          end
        end
`endif
        default: begin
          cur_st <= ST_STBY;
          duty_l <= '0;
          duty_r <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Randomized lockstep bench for motor_drive_sequencer against a per-clock behavioural model.
// Honours MOTOR_DRIVE_SEQUENCER_SOFTSTOP_EN so the same bench covers both builds.
module tb_motor_drive_sequencer;
  localparam int DIV_CNT     = 4;
  localparam int DUTY_W      = 7;
  localparam int DUTY_MAX    = 100;
  localparam int RAMP_STEP   = 1;
  localparam int BRAKE_TICKS = 2;
  localparam int WDT_TICKS   = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              v;
  logic              cdl, cdr;
  logic [DUTY_W-1:0] csl, csr;
  logic [DUTY_W-1:0] duty_l, duty_r;
  logic              ain1, ain2, bin1, bin2, stnby, fault;
  logic [2:0]        state;

  int n_tests = 0;
  int n_fail  = 0;
  int max_l   = 0;

  // Reference model state
  int m_st, m_cnt, m_dutl, m_dutr, m_tgtl, m_tgtr, m_wdt, m_bc;
  bit m_dirl, m_dirr, m_pl, m_pr;

  motor_drive_sequencer_if #(.DUTY_W(DUTY_W)) cmd_if ();

  assign cmd_if.cmd_valid = v;
  assign cmd_if.cmd_dir_l = cdl;
  assign cmd_if.cmd_spd_l = csl;
  assign cmd_if.cmd_dir_r = cdr;
  assign cmd_if.cmd_spd_r = csr;

  motor_drive_sequencer #(
    .DIV_CNT(DIV_CNT), .DUTY_W(DUTY_W), .DUTY_MAX(DUTY_MAX),
    .RAMP_STEP(RAMP_STEP), .BRAKE_TICKS(BRAKE_TICKS), .WDT_TICKS(WDT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .enable(en), .cmd(cmd_if),
    .duty_l(duty_l), .duty_r(duty_r),
    .ain1(ain1), .ain2(ain2), .bin1(bin1), .bin2(bin2),
    .stnby(stnby), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int approach(int cur, int goal);
    if (goal > cur) return cur + (((goal - cur) < RAMP_STEP) ? goal - cur : RAMP_STEP);
    if (goal < cur) return cur - (((cur - goal) < RAMP_STEP) ? cur - goal : RAMP_STEP);
    return cur;
  endfunction

  function automatic int clampd(int s);
    return (s > DUTY_MAX) ? DUTY_MAX : s;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_dutl = 0; m_dutr = 0; m_tgtl = 0; m_tgtr = 0;
    m_wdt = 0; m_bc = 0; m_dirl = 0; m_dirr = 0; m_pl = 0; m_pr = 0;
  endtask

  task automatic model_step(input bit tick);
    case (m_st)
      0: begin
        m_dutl = 0; m_dutr = 0; m_tgtl = 0; m_tgtr = 0;
        m_dirl = 0; m_dirr = 0; m_wdt = 0; m_bc = 0;
        if (en) m_st = 1;
      end
      1: begin
        if (!en) begin
`ifdef MOTOR_DRIVE_SEQUENCER_SOFTSTOP_EN
          m_st = 4;
`else
          m_st = 0; m_dutl = 0; m_dutr = 0;
`endif
        end else if (v && ((cdl != m_dirl && m_dutl != 0) || (cdr != m_dirr && m_dutr != 0))) begin
          m_st = 2; m_bc = 0; m_wdt = 0;
          m_tgtl = clampd(int'(csl)); m_tgtr = clampd(int'(csr));
          m_pl = cdl; m_pr = cdr; m_dutl = 0; m_dutr = 0;
        end else begin
          if (tick) begin
            m_dutl = approach(m_dutl, m_tgtl);
            m_dutr = approach(m_dutr, m_tgtr);
          end
          if (v) begin
            m_tgtl = clampd(int'(csl)); m_tgtr = clampd(int'(csr));
            m_dirl = cdl; m_dirr = cdr; m_wdt = 0;
          end else if (tick) begin
            m_wdt++;
            if (m_wdt == WDT_TICKS) begin
              m_st = 3; m_dutl = 0; m_dutr = 0;
            end
          end
        end
      end
      2: begin
        if (!en) m_st = 0;
        else if (tick) begin
          m_bc++;
          if (m_bc == BRAKE_TICKS) begin
            m_st = 1; m_dirl = m_pl; m_dirr = m_pr; m_bc = 0;
          end
        end
      end
      3: if (!en) m_st = 0;
      4: begin
        if (en) m_st = 1;
        else if (m_dutl == 0 && m_dutr == 0) m_st = 0;
        else if (tick) begin
          m_dutl = approach(m_dutl, 0);
          m_dutr = approach(m_dutr, 0);
        end
      end
      default: m_st = 0;
    endcase
  endtask

  function automatic int exp_pins();
    if (m_st == 1 || m_st == 4) return (m_dirl ? 4 : 8) | (m_dirr ? 1 : 2);
    if (m_st == 2 || m_st == 3) return 15;
    return 0;
  endfunction

  function automatic int exp_flags();
    return ((m_st != 0) ? 4 : 0) | ((m_st == 3) ? 2 : 0) | ((m_st == 1) ? 1 : 0);
  endfunction

  task automatic compare_all();
    check("state", 32'(state), m_st);
    check("duty_l", 32'(duty_l), m_dutl);
    check("duty_r", 32'(duty_r), m_dutr);
    check("pins", 32'({ain1, ain2, bin1, bin2}), exp_pins());
    check("stnby_fault_ready", 32'({stnby, fault, cmd_if.cmd_ready}), exp_flags());
  endtask

  task automatic run_cycle();
    bit tick;
    @(posedge clk);
    tick  = (m_cnt == DIV_CNT - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    model_step(tick);
    @(negedge clk);
    compare_all();
    if (int'(duty_l) > max_l) max_l = int'(duty_l);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic send(input logic dl, input int sl, input logic dr, input int sr);
    cdl = dl; csl = DUTY_W'(sl); cdr = dr; csr = DUTY_W'(sr);
    v = 1'b1;
    run_cycle();
    v = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; en = 1'b0; v = 1'b0;
    cdl = 1'b0; cdr = 1'b0; csl = '0; csr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("rst_ready", 32'(cmd_if.cmd_ready), 0);
    rst = 1'b0;
    run(1);
    en = 1'b1;
    run(1);
    check("start_state", 32'(state), 1);
    check("start_ain", 32'({ain1, ain2}), 2);

    // Soft-start ramp, then reversal brake on the left wheel
    send(0, 5, 0, 3);
    run(30);
    send(1, 5, 0, 3);
    run(40);
    // Right wheel ramps to zero then flips with no brake
    send(1, 5, 0, 0);
    run(20);
    send(1, 5, 1, 0);
    run(4);
    send(1, 5, 1, 4);
    run(20);

    // Watchdog expiry
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      run_cycle();
      found = (fault == 1'b1);
    end
    check("wdt_fault", 32'(fault), 1);
    en = 1'b0;
    run(2);
    check("fault_exit", 32'(state), 0);
    en = 1'b1;
    run(2);

    // Accept arriving on the expiring tick must win over the watchdog
    send(0, 5, 0, 5);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_st == 1 && m_wdt == WDT_TICKS - 1 && m_cnt == DIV_CNT - 1) found = 1;
      else run_cycle();
    end
    check("wdt_race_reached", 32'(found), 1);
    send(0, 5, 0, 5);
    check("wdt_race_no_fault", 32'(fault), 0);
    run(8);

    // Clamp: left target above DUTY_MAX
    max_l = 0;
    for (int k = 0; k < 11; k++) begin
      send(0, 120, 0, 0);
      run(39);
    end
    check("clamp_max", 32'(max_l), DUTY_MAX);

    en = 1'b0;
    for (int i = 0; i < 600 && state != 3'd0; i++) run_cycle();
    check("stby_reach", 32'(state), 0);
    en = 1'b1;
    run(1);

    // Disable with nonzero duty
    send(0, 5, 0, 2);
    run(30);
    en = 1'b0;
    run(1);
`ifdef MOTOR_DRIVE_SEQUENCER_SOFTSTOP_EN
    check("softstop_enter", 32'(state), 4);
`else
    check("disable_state", 32'(state), 0);
    check("disable_duty", 32'(duty_l), 0);
`endif
    run(30);
    en = 1'b1;
    run(1);
    send(0, 7, 0, 7);
    run(20);
    en = 1'b0;
    run(6);
    en = 1'b1;
    run(20);

    // Asynchronous reset in the middle of a brake
    send(0, 6, 0, 6);
    run(30);
    send(1, 6, 0, 6);
    run(2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_brake_state", 32'(state), 0);
    check("rst_brake_pins", 32'({ain1, ain2, bin1, bin2, stnby}), 0);
    check("rst_brake_duty", 32'(duty_l), 0);
    @(negedge clk);
    rst = 1'b0;
    run(2);

    // Randomized traffic, alternating busy and sparse command phases
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 250; i++) begin
        en  = ($urandom_range(0, 59) != 0);
        v   = (seg % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 149) == 0);
        cdl = 1'($urandom_range(0, 1));
        cdr = 1'($urandom_range(0, 1));
        csl = DUTY_W'($urandom_range(0, 127));
        csr = DUTY_W'($urandom_range(0, 127));
        run_cycle();
      end
    end
    v = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
